xilinx_fifo_verb: RTL and testbench
===================================

XILINX_FIFO_VERB -- requirements
Module: xilinx_fifo_verb

Interface
REQ-001 Parameter DSIZE, default 8: data word width in bits, minimum 1.
REQ-002 Parameter LENGTH, default 512: depth in words; power of two, minimum 2.
REQ-003 Port wr_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port wr_rst, input, 1: reset is synchronous and active-high.
REQ-005 Port rd_clk, input, 1: kept for drop-in compatibility; shall be tied to the wr_clk net; unused internally.
REQ-006 Port rd_rst, input, 1: synchronous active-high; effective reset rst = wr_rst OR rd_rst, sampled on wr_clk.
REQ-007 Port din, input, DSIZE: write data.
REQ-008 Port wr_en, input, 1: write request.
REQ-009 Port rd_en, input, 1: read/pop request.
REQ-010 Port dout, output, DSIZE: head-of-queue data, first-word fall-through (FWFT).
REQ-011 Port full, output, 1: no free entry.
REQ-012 Port empty, output, 1: no valid head word.

Function
REQ-013 Storage: LENGTH x DSIZE memory plus write pointer, read pointer and occupancy count of clog2(LENGTH)+1 bits.
REQ-014 Write accepted when wr_en=1 and full=0; din stored at write pointer; pointer wraps LENGTH-1 -> 0.
REQ-015 wr_en while full=1 is dropped; no contents or pointer change, even if rd_en=1 in the same cycle.
REQ-016 Pop accepted when rd_en=1 and empty=0; read pointer advances, wrapping LENGTH-1 -> 0.
REQ-017 rd_en while empty=1 is ignored; no state change.
REQ-018 FWFT: whenever empty=0, dout holds the oldest unread word, with no rd_en needed to present it.
REQ-019 After a pop, dout shows the next word the following cycle, or empty rises if none remain.
REQ-020 Latency: a word written into an empty FIFO at edge N gives empty=0 and valid dout after edge N+1; back-to-back one pop per cycle sustained.
REQ-021 empty, full and dout are registered outputs, glitch-free.
REQ-022 dout value while empty=1 is don't-care to users; it shall hold its last value.
REQ-023 Simultaneous accepted write and pop: count unchanged; full and empty unchanged except the empty-FIFO write-latency rule of REQ-020.
REQ-024 full=1 exactly when count equals LENGTH; full falls the cycle after a pop from full.
REQ-025 Order preserved; no word duplicated or lost among accepted writes.

Reset
REQ-026 While rst=1: pointers and count cleared, empty=1, full=0, dout=0; wr_en and rd_en ignored.
REQ-027 rst asserted mid-operation discards all contents at that edge; normal operation resumes the cycle after rst deasserts.
REQ-028 Memory array contents need not be reset.

Configuration
REQ-029 Macro XILINX_FIFO_VERB_STATUS_EN defined: adds outputs data_count [clog2(LENGTH)+1 bits] = registered occupancy, overflow (1-cycle pulse on wr_en while full) and underflow (1-cycle pulse on rd_en while empty); all cleared by rst.
REQ-030 Macro undefined: those three ports and their logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then write 0x11, 0x22, 0x33 on consecutive cycles, rd_en=0 -> empty falls one cycle after the first write; dout=0x11 held.
REQ-032 With LENGTH=4, write 5 words (0xA0..0xA4) -> full=1 after the 4th; 0xA4 dropped; draining yields 0xA0..0xA3, then empty=1.
REQ-033 With the FIFO full, assert wr_en=1 and rd_en=1 together -> pop accepted, write dropped; full falls next cycle.
REQ-034 With 2 words held, assert wr_en=1 and rd_en=1 continuously for 2*LENGTH cycles -> count constant; pointers wrap; output order is the input order.
REQ-035 rd_en=1 on empty FIFO -> no change; with macro defined, underflow pulses for 1 cycle.
REQ-036 Assert wr_rst while 3 words are held -> empty=1, full=0, dout=0 next cycle; a subsequent write of 0x5A is the next word read.

Source files
------------

// File: rtl/xilinx_fifo_verb.sv
// Single-clock first-word-fall-through FIFO with registered dout, empty and full.
// Defining XILINX_FIFO_VERB_STATUS_EN adds the data_count, overflow and underflow outputs.
module xilinx_fifo_verb #(
    parameter int DSIZE  = 8,
    parameter int LENGTH = 512
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic [DSIZE-1:0]          din,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [DSIZE-1:0]          dout,
    output logic                      full,
    output logic                      empty
`ifdef XILINX_FIFO_VERB_STATUS_EN
    ,
    output logic [$clog2(LENGTH):0]   data_count,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int AW = $clog2(LENGTH);
    localparam int CW = AW + 1;

    logic [DSIZE-1:0] mem_q [LENGTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    avail;
    logic [DSIZE-1:0] dout_q, dout_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             wr_acc, pop, rst;

    // rd_clk must be tied to wr_clk; it is not used inside.
    logic unused_rd_clk;
    assign unused_rd_clk = rd_clk;

    assign rst = wr_rst | rd_rst;

    always_comb begin
        wr_acc   = wr_en & ~full_q;
        pop      = rd_en & ~empty_q;
        // Only words already stored before this edge can become the new head;
        // a word written this edge shows up one cycle later.
        avail    = count_q - CW'(pop);
        count_d  = avail + CW'(wr_acc);
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        full_d   = (count_d == CW'(LENGTH));
        empty_d  = (avail == '0);
        dout_d   = dout_q;
        if (!empty_d) begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

`ifdef XILINX_FIFO_VERB_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_count = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
`endif

endmodule

// File: tb/tb_xilinx_fifo_verb.sv
// Self-checking bench for xilinx_fifo_verb (LENGTH=4): directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_xilinx_fifo_verb;

    localparam int DSIZE  = 8;
    localparam int LENGTH = 4;

    logic             clk;
    logic             rd_clk;
    logic             wr_rst;
    logic             rd_rst;
    logic [DSIZE-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [DSIZE-1:0] dout;
    logic             full;
    logic             empty;
`ifdef XILINX_FIFO_VERB_STATUS_EN
    logic [$clog2(LENGTH):0] data_count;
    logic                    overflow;
    logic                    underflow;
`endif

    assign rd_clk = clk;

    xilinx_fifo_verb #(
        .DSIZE (DSIZE),
        .LENGTH(LENGTH)
    ) dut (
        .wr_clk    (clk),
        .wr_rst    (wr_rst),
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty)
`ifdef XILINX_FIFO_VERB_STATUS_EN
        ,
        .data_count(data_count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: the queue holds every accepted, not yet popped word.
    logic [DSIZE-1:0] q[$];
    logic [DSIZE-1:0] exp_dout  = '0;
    logic             exp_empty = 1'b1;
    logic             exp_full  = 1'b0;
    logic             exp_ovf   = 1'b0;
    logic             exp_unf   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [DSIZE-1:0] d,
                       input logic wrs, input logic rrs);
        logic        acc_w;
        logic        acc_r;
        int unsigned old_size;
        wr_en  = w;
        rd_en  = r;
        din    = d;
        wr_rst = wrs;
        rd_rst = rrs;
        @(posedge clk);
        if (wrs || rrs) begin
            q.delete();
            exp_empty = 1'b1;
            exp_full  = 1'b0;
            exp_dout  = '0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            acc_w   = w && !exp_full;
            acc_r   = r && !exp_empty;
            exp_ovf = w && exp_full;
            exp_unf = r && exp_empty;
            if (acc_r) void'(q.pop_front());
            // A freshly written word is not visible until the following edge.
            old_size = q.size();
            if (acc_w) q.push_back(d);
            exp_empty = (old_size == 0);
            if (!exp_empty) exp_dout = q[0];
            exp_full = (q.size() == LENGTH);
        end
        @(negedge clk);
        check_eq("empty", {31'b0, empty}, {31'b0, exp_empty});
        check_eq("full",  {31'b0, full},  {31'b0, exp_full});
        check_eq("dout",  {24'b0, dout},  {24'b0, exp_dout});
`ifdef XILINX_FIFO_VERB_STATUS_EN
        check_eq("data_count", 32'(data_count), 32'(q.size()));
        check_eq("overflow",   {31'b0, overflow},  {31'b0, exp_ovf});
        check_eq("underflow",  {31'b0, underflow}, {31'b0, exp_unf});
`endif
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    endtask

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; din = '0; wr_rst = 1'b0; rd_rst = 1'b0;
        @(negedge clk);

        // Reset, then three consecutive writes; head 0x11 held.
        do_reset();
        cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        idle(2);

        // Five writes into depth four, then drain past empty.
        do_reset();
        for (int unsigned i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
        idle(1);
        for (int unsigned i = 0; i < 6; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Full FIFO with simultaneous write and read: pop taken, write dropped.
        do_reset();
        for (int unsigned i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b1, 8'hCF, 1'b0, 1'b0);
        idle(1);
        for (int unsigned i = 0; i < 4; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Two words held, streaming write+read for 2*LENGTH cycles.
        do_reset();
        cyc(1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        idle(1);
        for (int unsigned i = 0; i < 2 * LENGTH; i++) cyc(1'b1, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int unsigned i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);

        // Read from empty is ignored.
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle(1);

        // Reset mid-operation with three words held, then 0x5A is next out.
        for (int unsigned i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, '0, 1'b0, 1'b0);
        idle(1);

        // rd_rst alone also resets.
        cyc(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle(1);

        // Random traffic with occasional resets.
        for (int unsigned i = 0; i < 600; i++) begin
            logic w, r, wrs, rrs;
            w   = ($urandom_range(0, 99) < 55);
            r   = ($urandom_range(0, 99) < 50);
            wrs = ($urandom_range(0, 99) == 0);
            rrs = ($urandom_range(0, 149) == 0);
            cyc(w, r, 8'($urandom), wrs, rrs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
